// File: rtl/read_response_pkg.sv
// read_response_pkg: shared DMA widths, head/tuser field positions and keep helpers
package read_response_pkg;
    localparam int DATA_W         = 256;
    localparam int HEAD_W         = 128;
    localparam int KEEP_W         = 8;
    localparam int TUSER_W        = 128;
    localparam int BEAT_BYTES     = DATA_W / 8;
    localparam int CHNL_LSB       = 120;
    localparam int ADDR_LSB       = 32;
    localparam int LEN_W          = 13;
    localparam int TUSER_CHNL_LSB = 120;

    function automatic logic [3:0] keep_dws(input logic [KEEP_W-1:0] keep);
        keep_dws = '0;
        for (int i = 0; i < KEEP_W; i++) keep_dws = keep_dws + {3'd0, keep[i]};
    endfunction
endpackage

// File: rtl/read_response_if.sv
// read_response_if: request-info, completion-stream and response channels of read_response
interface read_response_if;
    import read_response_pkg::*;
    logic               rsp_info_valid;
    logic [HEAD_W-1:0]  rsp_info_head;
    logic               rsp_info_ready;
    logic               axis_rd_rsp_tvalid;
    logic               axis_rd_rsp_tlast;
    logic [DATA_W-1:0]  axis_rd_rsp_tdata;
    logic [TUSER_W-1:0] axis_rd_rsp_tuser;
    logic [KEEP_W-1:0]  axis_rd_rsp_tkeep;
    logic               axis_rd_rsp_tready;
    logic               dma_rd_rsp_valid;
    logic               dma_rd_rsp_last;
    logic [HEAD_W-1:0]  dma_rd_rsp_head;
    logic [DATA_W-1:0]  dma_rd_rsp_data;
    logic               dma_rd_rsp_ready;
    logic               rsp_err;

    modport slave (
        input  rsp_info_valid, rsp_info_head, output rsp_info_ready,
        input  axis_rd_rsp_tvalid, axis_rd_rsp_tlast, axis_rd_rsp_tdata, axis_rd_rsp_tuser, axis_rd_rsp_tkeep,
        output axis_rd_rsp_tready,
        output dma_rd_rsp_valid, dma_rd_rsp_last, dma_rd_rsp_head, dma_rd_rsp_data,
        input  dma_rd_rsp_ready,
        output rsp_err
    );
    modport master (
        output rsp_info_valid, rsp_info_head, input rsp_info_ready,
        output axis_rd_rsp_tvalid, axis_rd_rsp_tlast, axis_rd_rsp_tdata, axis_rd_rsp_tuser, axis_rd_rsp_tkeep,
        input  axis_rd_rsp_tready,
        input  dma_rd_rsp_valid, dma_rd_rsp_last, dma_rd_rsp_head, dma_rd_rsp_data,
        output dma_rd_rsp_ready,
        input  rsp_err
    );
endinterface

// File: rtl/read_response_rd_rsp_packer.sv
// rd_rsp_packer: 64-byte repack buffer; appends byte-shifted input at fill, drains beats from byte 0
module rd_rsp_packer
    import read_response_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_skip,
    input  logic [5:0]        in_cnt,
    input  logic              out_en,
    output logic [6:0]        fill,
    output logic [5:0]        drained,
    output logic [DATA_W-1:0] out_data
);
    logic [2*DATA_W-1:0] pack_q, pack_d, app;
    logic [DATA_W-1:0]   keep_mask;
    logic [6:0]          fill_q, fill_d, base;

    // bytes above fill are always zero, so appending is a plain OR
    always_comb begin
        drained   = out_en ? (fill_q >= 7'd32 ? 6'd32 : fill_q[5:0]) : 6'd0;
        base      = fill_q - {1'b0, drained};
        keep_mask = ~({DATA_W{1'b1}} << {in_cnt, 3'b000});
        app       = {{DATA_W{1'b0}}, (in_data >> {in_skip, 3'b000}) & keep_mask};
        pack_d    = (pack_q >> {drained, 3'b000}) | (in_en ? app << {base, 3'b000} : '0);
        fill_d    = base + (in_en ? {1'b0, in_cnt} : 7'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            fill_q <= '0;
        end else begin
            pack_q <= pack_d;
            fill_q <= fill_d;
        end
    end

    assign fill     = fill_q;
    assign out_data = pack_q[DATA_W-1:0];
endmodule

// File: rtl/read_response.sv
// read_response: pops request heads, strips offset/pad bytes from the in-order completion stream
// and returns one repacked DMA read response per request
module read_response
    import read_response_pkg::*;
(
    input logic            dma_clk,
    input logic            rst_n,
    read_response_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2;

    logic [1:0]        state_q, state_d, off_q, off_d, skip;
    logic [HEAD_W-1:0] head_q, head_d;
    logic [13:0]       byte_len_q, byte_len_d, dw_len_q, dw_len_d, dw_in_q, dw_in_d;
    logic [13:0]       bytes_in_q, bytes_in_d, bytes_out_q, bytes_out_d;
    logic [13:0]       info_len, room, n_eff, raw, rem;
    logic              err_q, err_d, pop, acc, over, valid, last, out_hs, unused_ok;
    logic [6:0]        fill;
    logic [5:0]        drained, cnt;
    logic [3:0]        n;
    logic [DATA_W-1:0] pk_data;

    assign valid    = fill >= 7'd32 || (fill != 7'd0 && bytes_in_q == byte_len_q);
    assign last     = valid && bytes_out_q + 14'd32 >= byte_len_q;
    assign out_hs   = valid && bus.dma_rd_rsp_ready;
    assign pop      = bus.rsp_info_valid && bus.rsp_info_ready;
    assign acc      = bus.axis_rd_rsp_tvalid && bus.axis_rd_rsp_tready;
    assign info_len = {1'b0, bus.rsp_info_head[LEN_W-1:0]};
    assign n        = keep_dws(bus.axis_rd_rsp_tkeep);
    assign room     = dw_len_q - dw_in_q;
    assign over     = {10'd0, n} > room;
    assign n_eff    = over ? room : {10'd0, n};
    // the address offset is skipped only in the very first DW of the request
    assign skip     = dw_in_q == 14'd0 ? off_q : 2'd0;
    assign raw      = {n_eff[11:0], 2'b00} > {12'd0, skip} ? {n_eff[11:0], 2'b00} - {12'd0, skip} : 14'd0;
    assign rem      = byte_len_q - bytes_in_q;
    assign cnt      = raw < rem ? raw[5:0] : rem[5:0];

    assign bus.rsp_info_ready     = state_q == IDLE && rst_n;
    assign bus.axis_rd_rsp_tready = state_q == STREAM && fill <= 7'd32 && dw_in_q < dw_len_q;
    assign bus.dma_rd_rsp_valid   = valid;
    assign bus.dma_rd_rsp_last    = last;
    assign bus.dma_rd_rsp_head    = head_q;
    assign bus.dma_rd_rsp_data    = pk_data;
    assign bus.rsp_err            = err_q;
    assign unused_ok = ^{bus.axis_rd_rsp_tlast, bus.axis_rd_rsp_tuser[TUSER_CHNL_LSB-1:0], n_eff[13:12]};

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        off_d       = off_q;
        byte_len_d  = byte_len_q;
        dw_len_d    = dw_len_q;
        dw_in_d     = dw_in_q;
        bytes_in_d  = bytes_in_q;
        bytes_out_d = bytes_out_q;
        err_d       = 1'b0;
        if (pop) begin
            if (info_len == 14'd0) err_d = 1'b1;
            else begin
                head_d      = bus.rsp_info_head;
                off_d       = bus.rsp_info_head[ADDR_LSB +: 2];
                byte_len_d  = info_len;
                dw_len_d    = (info_len + {12'd0, bus.rsp_info_head[ADDR_LSB +: 2]} + 14'd3) >> 2;
                dw_in_d     = '0;
                bytes_in_d  = '0;
                bytes_out_d = '0;
                state_d     = STREAM;
            end
        end
        if (acc) begin
            dw_in_d    = dw_in_q + n_eff;
            bytes_in_d = bytes_in_q + {8'd0, cnt};
            err_d      = over || bus.axis_rd_rsp_tuser[TUSER_CHNL_LSB +: 8] != head_q[CHNL_LSB +: 8];
            state_d    = dw_in_d == dw_len_q ? DRAIN : state_q;
        end
        if (out_hs) begin
            bytes_out_d = bytes_out_q + {8'd0, drained};
            state_d     = last ? IDLE : state_d;
        end
    end

    always_ff @(posedge dma_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            head_q      <= '0;
            off_q       <= '0;
            byte_len_q  <= '0;
            dw_len_q    <= '0;
            dw_in_q     <= '0;
            bytes_in_q  <= '0;
            bytes_out_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            off_q       <= off_d;
            byte_len_q  <= byte_len_d;
            dw_len_q    <= dw_len_d;
            dw_in_q     <= dw_in_d;
            bytes_in_q  <= bytes_in_d;
            bytes_out_q <= bytes_out_d;
            err_q       <= err_d;
        end
    end

    rd_rsp_packer u_packer (
        .clk     (dma_clk),
        .rst_n   (rst_n),
        .in_en   (acc),
        .in_data (bus.axis_rd_rsp_tdata),
        .in_skip (skip),
        .in_cnt  (cnt),
        .out_en  (out_hs),
        .fill    (fill),
        .drained (drained),
        .out_data(pk_data)
    );
endmodule

// File: tb/tb_read_response.sv
// tb_read_response: directed checks of repacking, backpressure, error pulses and reset
module tb_read_response;
    import read_response_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    logic [DATA_W-1:0] rec_data[$];
    logic              rec_last[$];
    logic [HEAD_W-1:0] rec_head[$];

    read_response_if bus();
    read_response dut (.dma_clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.dma_rd_rsp_valid && bus.dma_rd_rsp_ready) begin
            rec_data.push_back(bus.dma_rd_rsp_data);
            rec_last.push_back(bus.dma_rd_rsp_last);
            rec_head.push_back(bus.dma_rd_rsp_head);
        end
        if (bus.rsp_err) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] pat(input logic [7:0] seed, input int p);
        return 8'(int'(seed) + p * 7 + (p >> 8));
    endfunction

    function automatic logic [HEAD_W-1:0] mk_head(input logic [7:0] ch, input logic [63:0] addr, input logic [12:0] len);
        return {ch, 24'd0, addr, 19'd0, len};
    endfunction

    function automatic logic [DATA_W-1:0] in_beat(input logic [7:0] seed, input int i);
        logic [DATA_W-1:0] r;
        for (int j = 0; j < 32; j++) r[j*8 +: 8] = pat(seed, i * 32 + j);
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] exp_beat(input int off, input int len, input logic [7:0] seed, input int b);
        logic [DATA_W-1:0] r;
        for (int j = 0; j < 32; j++) r[j*8 +: 8] = (b * 32 + j < len) ? pat(seed, off + b * 32 + j) : 8'd0;
        return r;
    endfunction

    task automatic send_info(input logic [HEAD_W-1:0] h);
        int t = 0;
        bus.rsp_info_valid = 1'b1;
        bus.rsp_info_head  = h;
        @(negedge clk);
        while (!bus.rsp_info_ready && t < 300) begin @(negedge clk); t++; end
        total++;
        if (bus.rsp_info_ready !== 1'b1) begin bad++; $display("FAIL info_ready_timeout: got %b want 1", bus.rsp_info_ready); end
        @(posedge clk); #1;
        bus.rsp_info_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [7:0] k, input logic [7:0] ch, input logic l);
        int t = 0;
        bus.axis_rd_rsp_tvalid = 1'b1;
        bus.axis_rd_rsp_tdata  = d;
        bus.axis_rd_rsp_tkeep  = k;
        bus.axis_rd_rsp_tuser  = {ch, 120'd0};
        bus.axis_rd_rsp_tlast  = l;
        @(negedge clk);
        while (!bus.axis_rd_rsp_tready && t < 300) begin @(negedge clk); t++; end
        total++;
        if (bus.axis_rd_rsp_tready !== 1'b1) begin bad++; $display("FAIL tready_timeout: got %b want 1", bus.axis_rd_rsp_tready); end
        @(posedge clk); #1;
        bus.axis_rd_rsp_tvalid = 1'b0;
        bus.axis_rd_rsp_tlast  = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] seed, input int nb, input logic [7:0] last_keep, input int tlast_mid, input logic [7:0] ch);
        for (int i = 0; i < nb; i++)
            send_beat(in_beat(seed, i), i == nb - 1 ? last_keep : 8'hFF, ch, i == nb - 1 || i == tlast_mid);
    endtask

    task automatic settle(input int want);
        for (int t = 0; t < 400 && rec_data.size() < want; t++) begin @(negedge clk); #1; end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        total++; if (bus.dma_rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.dma_rd_rsp_valid); end
        total++; if (bus.dma_rd_rsp_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", bus.dma_rd_rsp_last); end
        total++; if (bus.dma_rd_rsp_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.dma_rd_rsp_data); end
        total++; if (bus.dma_rd_rsp_head !== '0) begin bad++; $display("FAIL rst_head: got %h want 0", bus.dma_rd_rsp_head); end
        total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.rsp_err); end
        total++; if (bus.axis_rd_rsp_tready !== 1'b0) begin bad++; $display("FAIL rst_tready: got %b want 0", bus.axis_rd_rsp_tready); end
        total++; if (bus.rsp_info_ready !== 1'b0) begin bad++; $display("FAIL rst_info_ready: got %b want 0", bus.rsp_info_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.rsp_info_ready !== 1'b1) begin bad++; $display("FAIL idle_info_ready: got %b want 1", bus.rsp_info_ready); end
    endtask

    task automatic test_aligned();
        int base = rec_data.size();
        int e0 = err_cnt;
        logic [HEAD_W-1:0] h = mk_head(8'd3, 64'h1000, 13'd64);
        send_info(h);
        send_data(8'h11, 2, 8'hFF, -1, 8'd3);
        settle(base + 2);
        total++; if (rec_data.size() !== base + 2) begin bad++; $display("FAIL aligned_count: got %0d want 2", rec_data.size() - base); end
        for (int b = 0; b < 2 && base + b < rec_data.size(); b++) begin
            total++; if (rec_data[base+b] !== in_beat(8'h11, b)) begin bad++; $display("FAIL aligned_data[%0d]: got %h want %h", b, rec_data[base+b], in_beat(8'h11, b)); end
            total++; if (rec_last[base+b] !== (b == 1)) begin bad++; $display("FAIL aligned_last[%0d]: got %b want %b", b, rec_last[base+b], b == 1); end
        end
        if (rec_head.size() > base) begin
            total++; if (rec_head[base] !== h) begin bad++; $display("FAIL aligned_head: got %h want %h", rec_head[base], h); end
        end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL aligned_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_unaligned();
        int base = rec_data.size();
        send_info(mk_head(8'd1, 64'h1003, 13'd5));
        send_data(8'h40, 1, 8'h03, -1, 8'd1);
        settle(base + 1);
        total++; if (rec_data.size() !== base + 1) begin bad++; $display("FAIL unaligned_count: got %0d want 1", rec_data.size() - base); end
        if (rec_data.size() > base) begin
            total++; if (rec_data[base] !== exp_beat(3, 5, 8'h40, 0)) begin bad++; $display("FAIL unaligned_data: got %h want %h", rec_data[base], exp_beat(3, 5, 8'h40, 0)); end
            total++; if (rec_last[base] !== 1'b1) begin bad++; $display("FAIL unaligned_last: got %b want 1", rec_last[base]); end
        end
    endtask

    task automatic test_split();
        int base = rec_data.size();
        send_info(mk_head(8'd2, 64'h2002, 13'd256));
        send_data(8'h5A, 9, 8'h01, 7, 8'd2);
        settle(base + 8);
        total++; if (rec_data.size() !== base + 8) begin bad++; $display("FAIL split_count: got %0d want 8", rec_data.size() - base); end
        for (int b = 0; b < 8 && base + b < rec_data.size(); b++) begin
            total++; if (rec_data[base+b] !== exp_beat(2, 256, 8'h5A, b)) begin bad++; $display("FAIL split_data[%0d]: got %h want %h", b, rec_data[base+b], exp_beat(2, 256, 8'h5A, b)); end
            total++; if (rec_last[base+b] !== (b == 7)) begin bad++; $display("FAIL split_last[%0d]: got %b want %b", b, rec_last[base+b], b == 7); end
        end
    endtask

    task automatic test_backpressure();
        int base = rec_data.size();
        int e0 = err_cnt;
        send_info(mk_head(8'd4, 64'h3001, 13'd200));
        fork
            send_data(8'h77, 7, 8'h07, -1, 8'd4);
            begin
                for (int t = 0; t < 300 && rec_data.size() < base + 2; t++) begin @(negedge clk); #1; end
                @(posedge clk); #1;
                bus.dma_rd_rsp_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                total++; if (bus.axis_rd_rsp_tready !== 1'b0) begin bad++; $display("FAIL bp_tready: got %b want 0", bus.axis_rd_rsp_tready); end
                total++; if (bus.dma_rd_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold: got %b want 1", bus.dma_rd_rsp_valid); end
                total++; if (rec_data.size() !== base + 2) begin bad++; $display("FAIL bp_hold_count: got %0d want 2", rec_data.size() - base); end
                bus.dma_rd_rsp_ready = 1'b1;
            end
        join
        settle(base + 7);
        total++; if (rec_data.size() !== base + 7) begin bad++; $display("FAIL bp_count: got %0d want 7", rec_data.size() - base); end
        for (int b = 0; b < 7 && base + b < rec_data.size(); b++) begin
            total++; if (rec_data[base+b] !== exp_beat(1, 200, 8'h77, b)) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", b, rec_data[base+b], exp_beat(1, 200, 8'h77, b)); end
            total++; if (rec_last[base+b] !== (b == 6)) begin bad++; $display("FAIL bp_last[%0d]: got %b want %b", b, rec_last[base+b], b == 6); end
        end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL bp_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_errors();
        int base = rec_data.size();
        int e0 = err_cnt;
        send_info(mk_head(8'd3, 64'h4000, 13'd32));
        send_data(8'h21, 1, 8'hFF, -1, 8'd5);
        settle(base + 1);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL chnl_err_pulses: got %0d want 1", err_cnt - e0); end
        total++; if (rec_data.size() !== base + 1) begin bad++; $display("FAIL chnl_count: got %0d want 1", rec_data.size() - base); end
        if (rec_data.size() > base) begin
            total++; if (rec_data[base] !== exp_beat(0, 32, 8'h21, 0)) begin bad++; $display("FAIL chnl_data: got %h want %h", rec_data[base], exp_beat(0, 32, 8'h21, 0)); end
            total++; if (rec_last[base] !== 1'b1) begin bad++; $display("FAIL chnl_last: got %b want 1", rec_last[base]); end
        end
        base = rec_data.size();
        e0 = err_cnt;
        send_info(mk_head(8'd3, 64'h5000, 13'd8));
        send_data(8'h33, 1, 8'hFF, -1, 8'd3);
        settle(base + 1);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL over_err_pulses: got %0d want 1", err_cnt - e0); end
        total++; if (rec_data.size() !== base + 1) begin bad++; $display("FAIL over_count: got %0d want 1", rec_data.size() - base); end
        if (rec_data.size() > base) begin
            total++; if (rec_data[base] !== exp_beat(0, 8, 8'h33, 0)) begin bad++; $display("FAIL over_data: got %h want %h", rec_data[base], exp_beat(0, 8, 8'h33, 0)); end
        end
        e0 = err_cnt;
        send_info(mk_head(8'd3, 64'h8000, 13'd0));
        repeat (3) @(posedge clk);
        #1;
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL len0_err_pulses: got %0d want 1", err_cnt - e0); end
        total++; if (bus.rsp_info_ready !== 1'b1) begin bad++; $display("FAIL len0_idle: got %b want 1", bus.rsp_info_ready); end
    endtask

    task automatic test_reset_mid();
        int base;
        send_info(mk_head(8'd6, 64'h6000, 13'd128));
        send_data(8'h90, 2, 8'hFF, -1, 8'd6);
        rst_n = 1'b0;
        #1;
        total++; if (bus.dma_rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.dma_rd_rsp_valid); end
        total++; if (bus.dma_rd_rsp_data !== '0) begin bad++; $display("FAIL mid_rst_data: got %h want 0", bus.dma_rd_rsp_data); end
        total++; if (bus.dma_rd_rsp_head !== '0) begin bad++; $display("FAIL mid_rst_head: got %h want 0", bus.dma_rd_rsp_head); end
        total++; if (bus.axis_rd_rsp_tready !== 1'b0) begin bad++; $display("FAIL mid_rst_tready: got %b want 0", bus.axis_rd_rsp_tready); end
        total++; if (bus.dma_rd_rsp_last !== 1'b0) begin bad++; $display("FAIL mid_rst_last: got %b want 0", bus.dma_rd_rsp_last); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = rec_data.size();
        send_info(mk_head(8'd2, 64'h7004, 13'd96));
        send_data(8'hC3, 3, 8'hFF, -1, 8'd2);
        settle(base + 3);
        total++; if (rec_data.size() !== base + 3) begin bad++; $display("FAIL post_rst_count: got %0d want 3", rec_data.size() - base); end
        for (int b = 0; b < 3 && base + b < rec_data.size(); b++) begin
            total++; if (rec_data[base+b] !== exp_beat(0, 96, 8'hC3, b)) begin bad++; $display("FAIL post_rst_data[%0d]: got %h want %h", b, rec_data[base+b], exp_beat(0, 96, 8'hC3, b)); end
            total++; if (rec_last[base+b] !== (b == 2)) begin bad++; $display("FAIL post_rst_last[%0d]: got %b want %b", b, rec_last[base+b], b == 2); end
        end
    endtask

    initial begin
        bus.rsp_info_valid     = 1'b0;
        bus.rsp_info_head      = '0;
        bus.axis_rd_rsp_tvalid = 1'b0;
        bus.axis_rd_rsp_tlast  = 1'b0;
        bus.axis_rd_rsp_tdata  = '0;
        bus.axis_rd_rsp_tuser  = '0;
        bus.axis_rd_rsp_tkeep  = '0;
        bus.dma_rd_rsp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_aligned();
        test_unaligned();
        test_split();
        test_backpressure();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
